// File: rtl/mc_defs.sv
// Shared constants for the multicycle MIPS main control: opcodes, shift functs,
// FSM state codes, ALUOp codes and the control-word layout.
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_ADDIU = 4'b0010;
    localparam logic [3:0] ALU_ANDI  = 4'b0011;
    localparam logic [3:0] ALU_LUI   = 4'b0100;
    localparam logic [3:0] ALU_ORI   = 4'b0101;
    localparam logic [3:0] ALU_SLTI  = 4'b0110;
    localparam logic [3:0] ALU_SLTIU = 4'b0111;
    localparam logic [3:0] ALU_XORI  = 4'b1000;
    localparam logic [3:0] ALU_RTYPE = 4'b1100;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_IEX   = 4'd10,
        S_IWB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       bne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [3:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'(20'd0);

    // Shift-by-shamt R-type functions take operand A from the shamt field.
    function automatic logic is_shift(input logic [5:0] funct);
        logic r;
        case (funct)
            FN_SLL, FN_SRL, FN_SRA: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] imm_aluop(input logic [5:0] op);
        logic [3:0] r;
        case (op)
            OP_ADDIU: r = ALU_ADDIU;
            OP_ANDI:  r = ALU_ANDI;
            OP_LUI:   r = ALU_LUI;
            OP_ORI:   r = ALU_ORI;
            OP_SLTI:  r = ALU_SLTI;
            OP_SLTIU: r = ALU_SLTIU;
            OP_XORI:  r = ALU_XORI;
            default:  r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mc_main_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Bne;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALUOp;
    logic [3:0] state;

    modport master (
        input  op, funct,
        output PCWrite, PCWriteCond, Bne, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, state
    );

    modport slave (
        output op, funct,
        input  PCWrite, PCWriteCond, Bne, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, state
    );
endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state function of the main control FSM.
module mc_next_state
    import mc_defs::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    output state_t     next
);

    // Instruction sequencing; unknown opcodes retire from ID, illegal codes recover to IF.
    always_comb begin
        next = S_IF;
        case (state)
            S_IF: next = S_ID;
            S_ID: begin
                case (op)
                    OP_LW, OP_SW:     next = S_MADDR;
                    OP_RTYPE:         next = S_REX;
                    OP_BEQ, OP_BNE:   next = S_BR;
                    OP_J:             next = S_JMP;
                    OP_ADDIU, OP_ANDI, OP_LUI, OP_ORI,
                    OP_SLTI, OP_SLTIU, OP_XORI: next = S_IEX;
                    default:          next = S_IF;
                endcase
            end
            S_MADDR: begin
                if (op == OP_LW) begin
                    next = S_MRD;
                end else begin
                    next = S_MWR;
                end
            end
            S_MRD:   next = S_MWB;
            S_REX:   next = S_RWB;
            S_IEX:   next = S_IWB;
            S_MWB, S_MWR, S_RWB, S_BR, S_JMP, S_IWB: next = S_IF;
            default: next = S_IF;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core. Control outputs are registered
// from the decode of the next state, so they always match the state register.
module mc_main_ctrl
    import mc_defs::*;
(
    input  logic          clk,
    input  logic          rst,
    mc_main_ctrl_if.master bus
);

    state_t state_r;
    state_t next_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_next_s;
    ctrl_t  ctrl_out_s;

    function automatic ctrl_t decode(input state_t st, input logic [5:0] op,
                                     input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            S_IF: begin
                c.memread  = 1'b1;
                c.irwrite  = 1'b1;
                c.pcwrite  = 1'b1;
                c.alusrcb  = 2'b01;
            end
            S_ID:    c.alusrcb = 2'b11;
            S_MADDR: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
            end
            S_MRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_REX: begin
                c.aluop = ALU_RTYPE;
                if (is_shift(funct)) begin
                    c.alusrca = 2'b10;
                end else begin
                    c.alusrca = 2'b01;
                end
            end
            S_RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BR: begin
                c.alusrca     = 2'b01;
                c.aluop       = ALU_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.bne         = (op == OP_BNE);
            end
            S_JMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            S_IEX: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.aluop   = imm_aluop(op);
            end
            S_IWB:   c.regwrite = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    mc_next_state u_next_state (
        .state (state_r),
        .op    (bus.op),
        .next  (next_s)
    );

    // Decode of the state about to be entered; IR is stable from ID on.
    always_comb begin
        ctrl_next_s = decode(next_s, bus.op, bus.funct);
    end

    // State and control-word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IF;
            ctrl_r  <= decode(S_IF, OP_RTYPE, FN_SLL);
        end else begin
            state_r <= next_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    // Reset masks every strobe at once; IF controls appear on release.
    always_comb begin
        if (rst) begin
            ctrl_out_s = CTRL_IDLE;
        end else begin
            ctrl_out_s = ctrl_r;
        end
    end

    assign bus.PCWrite     = ctrl_out_s.pcwrite;
    assign bus.PCWriteCond = ctrl_out_s.pcwritecond;
    assign bus.Bne         = ctrl_out_s.bne;
    assign bus.IorD        = ctrl_out_s.iord;
    assign bus.MemRead     = ctrl_out_s.memread;
    assign bus.MemWrite    = ctrl_out_s.memwrite;
    assign bus.IRWrite     = ctrl_out_s.irwrite;
    assign bus.MemtoReg    = ctrl_out_s.memtoreg;
    assign bus.RegDst      = ctrl_out_s.regdst;
    assign bus.RegWrite    = ctrl_out_s.regwrite;
    assign bus.ALUSrcA     = ctrl_out_s.alusrca;
    assign bus.ALUSrcB     = ctrl_out_s.alusrcb;
    assign bus.PCSource    = ctrl_out_s.pcsource;
    assign bus.ALUOp       = ctrl_out_s.aluop;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: expected per-cycle state/control words are
// queued by the driver and checked by a negedge monitor.
module tb_mc_main_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [3:0]  st;
        logic [19:0] vec;
        string       name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mc_main_ctrl_if bus ();

    mc_main_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [19:0] obs_s;
    always_comb begin
        obs_s = {bus.PCWrite, bus.PCWriteCond, bus.Bne, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                 bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp};
    end

    function automatic logic [19:0] mk(input logic pcw, input logic pcwc, input logic bne,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rd,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] ps, input logic [3:0] aop);
        return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, a, b, ps, aop};
    endfunction

    logic [19:0] e_if, e_id, e_maddr, e_mrd, e_mwb, e_mwr, e_rwb, e_jmp, e_iwb;
    initial begin
        e_if    = mk(1,0,0,0,1,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 4'b0000);
        e_id    = mk(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 4'b0000);
        e_maddr = mk(0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 4'b0000);
        e_mrd   = mk(0,0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000);
        e_mwb   = mk(0,0,0,0,0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 4'b0000);
        e_mwr   = mk(0,0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000);
        e_rwb   = mk(0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 4'b0000);
        e_jmp   = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 4'b0000);
        e_iwb   = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000);
    end

    function automatic logic [19:0] e_rex(input logic [1:0] a);
        return mk(0,0,0,0,0,0,0,0,0,0, a, 2'b00, 2'b00, 4'b1100);
    endfunction

    function automatic logic [19:0] e_br(input logic bne);
        return mk(0,1,bne,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b01, 4'b0001);
    endfunction

    function automatic logic [19:0] e_iex(input logic [3:0] aop);
        return mk(0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, aop);
    endfunction

    // Hand table of cycles per instruction by opcode.
    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'b100011:                         return 5;
            6'b101011, 6'b000000, 6'b001001, 6'b001100, 6'b001111,
            6'b001101, 6'b001010, 6'b001011, 6'b001110: return 4;
            6'b000100, 6'b000101, 6'b000010:   return 3;
            default:                           return 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got state/ctrl %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [19:0] vec, input string name);
        exp_t e;
        e.st = st;
        e.vec = vec;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic run(input int n, input string name);
        repeat (n) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d expected cycles left, expected 0", name, q.size());
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] funct);
        bus.op = op;
        bus.funct = funct;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty: state %0d seen, no expected entry", bus.state);
            end else begin
                exp_t e;
                e = q.pop_front();
                check(e.name, {bus.state, obs_s}, {e.st, e.vec});
            end
        end
    end

    // Invariant monitor: no read/write overlap, never two PC load sources.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ((bus.MemRead && bus.MemWrite) || (bus.PCWrite && bus.PCWriteCond)) begin
                fails++;
                $display("FAIL invariant: MemRead=%b MemWrite=%b PCWrite=%b PCWriteCond=%b, expected no overlap",
                         bus.MemRead, bus.MemWrite, bus.PCWrite, bus.PCWriteCond);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        instr(6'b000000, 6'b000000);
        repeat (2) @(posedge clk);
        #2;
        check("reset_hold", {bus.state, obs_s}, 24'h000000);
        rst = 1'b0;
        chk_en = 1'b1;

        instr(6'b100011, 6'b000000);
        push(4'd0, e_if, "lw_if"); push(4'd1, e_id, "lw_id"); push(4'd2, e_maddr, "lw_maddr");
        push(4'd3, e_mrd, "lw_mrd"); push(4'd4, e_mwb, "lw_mwb");
        run(5, "lw");

        instr(6'b000000, 6'b000000);
        push(4'd0, e_if, "sll_if"); push(4'd1, e_id, "sll_id");
        push(4'd6, e_rex(2'b10), "sll_rex"); push(4'd7, e_rwb, "sll_rwb");
        run(4, "sll");

        instr(6'b000000, 6'b100000);
        push(4'd0, e_if, "add_if"); push(4'd1, e_id, "add_id");
        push(4'd6, e_rex(2'b01), "add_rex"); push(4'd7, e_rwb, "add_rwb");
        run(4, "add");

        instr(6'b000000, 6'b000011);
        push(4'd0, e_if, "sra_if"); push(4'd1, e_id, "sra_id");
        push(4'd6, e_rex(2'b10), "sra_rex"); push(4'd7, e_rwb, "sra_rwb");
        run(4, "sra");

        instr(6'b000101, 6'b000000);
        push(4'd0, e_if, "bne_if"); push(4'd1, e_id, "bne_id"); push(4'd8, e_br(1'b1), "bne_br");
        run(3, "bne");

        instr(6'b000100, 6'b000000);
        push(4'd0, e_if, "beq_if"); push(4'd1, e_id, "beq_id"); push(4'd8, e_br(1'b0), "beq_br");
        run(3, "beq");

        instr(6'b001101, 6'b000000);
        push(4'd0, e_if, "ori_if"); push(4'd1, e_id, "ori_id");
        push(4'd10, e_iex(4'b0101), "ori_iex"); push(4'd11, e_iwb, "ori_iwb");
        run(4, "ori");

        instr(6'b001111, 6'b000000);
        push(4'd0, e_if, "lui_if"); push(4'd1, e_id, "lui_id");
        push(4'd10, e_iex(4'b0100), "lui_iex"); push(4'd11, e_iwb, "lui_iwb");
        run(4, "lui");

        instr(6'b001011, 6'b000000);
        push(4'd0, e_if, "sltiu_if"); push(4'd1, e_id, "sltiu_id");
        push(4'd10, e_iex(4'b0111), "sltiu_iex"); push(4'd11, e_iwb, "sltiu_iwb");
        run(4, "sltiu");

        instr(6'b001110, 6'b000000);
        push(4'd0, e_if, "xori_if"); push(4'd1, e_id, "xori_id");
        push(4'd10, e_iex(4'b1000), "xori_iex"); push(4'd11, e_iwb, "xori_iwb");
        run(4, "xori");

        instr(6'b111111, 6'b000000);
        push(4'd0, e_if, "undef_if"); push(4'd1, e_id, "undef_id");
        run(2, "undef");

        // sw interrupted by reset while in MWR.
        instr(6'b101011, 6'b000000);
        push(4'd0, e_if, "sw_if"); push(4'd1, e_id, "sw_id"); push(4'd2, e_maddr, "sw_maddr");
        run(3, "sw");
        chk_en = 1'b0;
        check("sw_mwr", {bus.state, obs_s}, {4'd5, e_mwr});
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_mwr", {bus.state, obs_s}, 24'h000000);
        @(posedge clk);
        #2;
        check("rst_held", {bus.state, obs_s}, 24'h000000);
        rst = 1'b0;
        chk_en = 1'b1;

        instr(6'b000010, 6'b000000);
        push(4'd0, e_if, "j_if"); push(4'd1, e_id, "j_id"); push(4'd9, e_jmp, "j_jmp");
        run(3, "j");
        chk_en = 1'b0;

        // Sweep every opcode and check its cycle count.
        for (int op = 0; op < 64; op++) begin
            logic [5:0] op6;
            int n;
            op6 = op[5:0];
            instr(op6, op6);
            n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (bus.state != 4'd0 && n < 8);
            tests++;
            if (n != cpi(op6)) begin
                fails++;
                $display("FAIL cpi_op%02h: got %0d cycles, expected %0d", op6, n, cpi(op6));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
